// File: rtl/bnn_pkg.sv
//==============================================================================
// bnn_pkg : shared SPI responder state encoding and status-byte field layout
// Rev 1.0
//==============================================================================
`default_nettype none

package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } spi_state_t;

  localparam int c_STAT_RDY_BIT = 7;
  localparam int c_STAT_FSM_MSB = 6;
  localparam int c_STAT_FSM_LSB = 4;
  localparam int c_STAT_DIG_MSB = 3;
  localparam int c_STAT_DIG_LSB = 0;

  function automatic logic [7:0] pack_status(input logic       rdy,
                                             input logic [2:0] st,
                                             input logic [3:0] dig);
    logic [7:0] s;
    s = 8'h00;
    s[c_STAT_RDY_BIT]                 = rdy;
    s[c_STAT_FSM_MSB:c_STAT_FSM_LSB]  = st;
    s[c_STAT_DIG_MSB:c_STAT_DIG_LSB]  = dig;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_responder_if.sv
//==============================================================================
// spi_tx_responder_if : response-byte valid/ready handshake into the responder
// Rev 1.0
//==============================================================================
`default_nettype none

interface spi_tx_responder_if;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_byte, output tx_valid, input  tx_ready);
  modport slave  (input  tx_byte, input  tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/bit_synchronizer.sv
//==============================================================================
// bit_synchronizer : DEPTH-flop single-bit synchronizer with selectable reset value
// Rev 1.0
//==============================================================================
`default_nettype none

module bit_synchronizer #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {DEPTH{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], d};
    end
  end

  assign q = r_sync[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/spi_tx_responder.sv
//==============================================================================
// spi_tx_responder : SPI mode-0 MISO responder, one-byte holding register, status fallback
// Rev 1.0
//==============================================================================
`default_nettype none

module spi_tx_responder
  import bnn_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int CLK_SCLK_MIN_RATIO = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sclk,
  input  logic                      cs_n,
  output logic                      miso,
  output logic                      miso_oe,
  spi_tx_responder_if.slave         tx,
  input  logic [2:0]                fsm_state,
  input  logic                      bnn_result_ready,
  input  logic [3:0]                bnn_result_out,
  output logic                      byte_done,
  output logic                      status_sent
);

  if (SYNC_STAGES < 2 || CLK_SCLK_MIN_RATIO < 2) begin : g_param_check
    $error("spi_tx_responder: SYNC_STAGES must be >= 2 and CLK_SCLK_MIN_RATIO >= 2");
  end

  logic       w_sclk_s;
  logic       w_cs_s;
  logic       r_sclk_prev;
  logic       r_cs_prev;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_fall;

  spi_state_t r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_hold;
  logic       r_hold_valid;
  logic       r_is_status;

  bit_synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sclk),
    .q     (w_sclk_s)
  );

  bit_synchronizer #(.DEPTH(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .q     (w_cs_s)
  );

  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
  assign w_cs_fall   = ~w_cs_s & r_cs_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 8'h00;
      r_hold       <= 8'h00;
      r_hold_valid <= 1'b0;
      r_is_status  <= 1'b0;
      r_sclk_prev  <= 1'b0;
      r_cs_prev    <= 1'b1;
      byte_done    <= 1'b0;
      status_sent  <= 1'b0;
    end else begin
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
      byte_done   <= 1'b0;
      status_sent <= 1'b0;

      // Accept only into an empty holding register, so a LOAD that drains it
      // can never coincide with a new write.
      if (tx.tx_valid && !r_hold_valid) begin
        r_hold       <= tx.tx_byte;
        r_hold_valid <= 1'b1;
      end

      if (w_cs_s) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= 3'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) r_state <= ST_LOAD;
          end
          ST_LOAD: begin
            if (r_hold_valid) begin
              r_shift      <= r_hold;
              r_hold_valid <= 1'b0;
              r_is_status  <= 1'b0;
            end else begin
              r_shift     <= pack_status(bnn_result_ready, fsm_state, bnn_result_out);
              r_is_status <= 1'b1;
            end
            r_bit_cnt <= 3'd0;
            r_state   <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                byte_done   <= 1'b1;
                status_sent <= r_is_status;
                r_state     <= ST_LOAD;
              end
            end else if (w_sclk_fall && (r_bit_cnt != 3'd0)) begin
              // The fall after the final rise is skipped; LOAD refills instead.
              r_shift <= {r_shift[6:0], 1'b0};
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign tx.tx_ready = ~r_hold_valid;
  assign miso_oe     = ~w_cs_s;
  assign miso        = miso_oe & r_shift[7];

endmodule

`default_nettype wire

// File: tb/tb_spi_tx_responder.sv
//==============================================================================
// tb_spi_tx_responder : directed scenarios plus randomized frames against a byte-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_spi_tx_responder;

  localparam int SYNC_STAGES        = 2;
  localparam int CLK_SCLK_MIN_RATIO = 8;
  localparam int SH                 = 8;   // clk cycles per sclk half period (clk/16)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk;
  logic       cs_n;
  logic       miso;
  logic       miso_oe;
  logic [2:0] fsm_state;
  logic       bnn_result_ready;
  logic [3:0] bnn_result_out;
  logic       byte_done;
  logic       status_sent;

  spi_tx_responder_if tx_if ();

  spi_tx_responder #(
    .SYNC_STAGES        (SYNC_STAGES),
    .CLK_SCLK_MIN_RATIO (CLK_SCLK_MIN_RATIO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .sclk             (sclk),
    .cs_n             (cs_n),
    .miso             (miso),
    .miso_oe          (miso_oe),
    .tx               (tx_if),
    .fsm_state        (fsm_state),
    .bnn_result_ready (bnn_result_ready),
    .bnn_result_out   (bnn_result_out),
    .byte_done        (byte_done),
    .status_sent      (status_sent)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Pulse monitors, sampled away from the active edge
  int bd_cnt    = 0;
  int ss_cnt    = 0;
  int ss_orphan = 0;
  always @(negedge clk) begin
    if (byte_done)                 bd_cnt++;
    if (status_sent)               ss_cnt++;
    if (status_sent && !byte_done) ss_orphan++;
  end

  logic [7:0] rx [0:7];
  int         rx_n;
  logic [7:0] model_q [$];

  function automatic logic [7:0] status_now();
    return {bnn_result_ready, fsm_state, bnn_result_out};
  endfunction

  task automatic push(input logic [7:0] b);
    int t = 0;
    while (!tx_if.tx_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("push_ready", tx_if.tx_ready, 1'b1);
    tx_if.tx_byte  = b;
    tx_if.tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_if.tx_valid = 1'b0;
  endtask

  // Host master: cs_n low, nbits mode-0 clocks sampling miso at each rise, cs_n high
  task automatic host_frame(input int nbits);
    logic [7:0] sh;
    sh   = 8'h00;
    rx_n = 0;
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < nbits; i++) begin
      repeat (SH) @(posedge clk);
      #1 sh = {sh[6:0], miso};
      sclk = 1'b1;
      repeat (SH) @(posedge clk);
      #1 sclk = 1'b0;
      if ((i % 8) == 7) begin
        rx[rx_n] = sh;
        rx_n++;
      end
    end
    repeat (SH) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bd0, ss0, nb, nbits, exp_ss;
    logic [7:0] e, d;

    assert (2 * SH >= CLK_SCLK_MIN_RATIO)
      else begin
        $display("FAIL clk_sclk_ratio: got %0d required >= %0d", 2 * SH, CLK_SCLK_MIN_RATIO);
        $fatal(1);
      end

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1;
    tx_if.tx_byte = 8'h00; tx_if.tx_valid = 1'b0;
    fsm_state = 3'd0; bnn_result_ready = 1'b0; bnn_result_out = 4'd0;

    repeat (3) @(posedge clk); #1;
    check("rst_miso",        miso,           1'b0);
    check("rst_miso_oe",     miso_oe,        1'b0);
    check("rst_tx_ready",    tx_if.tx_ready, 1'b1);
    check("rst_byte_done",   byte_done,      1'b0);
    check("rst_status_sent", status_sent,    1'b0);

    // Release and push on the very first edge afterwards
    rst_n = 1'b1;
    tx_if.tx_byte = 8'hC3; tx_if.tx_valid = 1'b1;
    @(posedge clk); #1 tx_if.tx_valid = 1'b0;
    check("first_edge_accept", tx_if.tx_ready, 1'b0);

    // Pushed byte C3
    bd0 = bd_cnt; ss0 = ss_cnt;
    host_frame(8);
    check("c3_byte",        rx[0],          8'hC3);
    check("c3_byte_done",   bd_cnt - bd0,   1);
    check("c3_status_sent", ss_cnt - ss0,   0);
    check("c3_tx_ready",    tx_if.tx_ready, 1'b1);
    check("idle_miso_oe",   miso_oe,        1'b0);
    check("idle_miso",      miso,           1'b0);

    // Status fallback
    fsm_state = 3'd5; bnn_result_ready = 1'b1; bnn_result_out = 4'd7;
    bd0 = bd_cnt; ss0 = ss_cnt;
    host_frame(8);
    check("status_byte",      rx[0],        8'hD7);
    check("status_byte_done", bd_cnt - bd0, 1);
    check("status_sent",      ss_cnt - ss0, 1);

    // Back-to-back bytes A5, 3C in one 16-clock frame
    push(8'hA5);
    bd0 = bd_cnt; ss0 = ss_cnt;
    fork
      host_frame(16);
      push(8'h3C);
    join
    check("b2b_byte0",     rx[0],        8'hA5);
    check("b2b_byte1",     rx[1],        8'h3C);
    check("b2b_byte_done", bd_cnt - bd0, 2);
    check("b2b_status",    ss_cnt - ss0, 0);

    // Abort after 4 clocks: F0 lost
    push(8'hF0);
    bd0 = bd_cnt;
    host_frame(4);
    check("abort_no_done", bd_cnt - bd0, 0);
    bd0 = bd_cnt; ss0 = ss_cnt;
    host_frame(8);
    check("abort_next_byte",   rx[0],        8'hD7);
    check("abort_next_status", ss_cnt - ss0, 1);
    check("abort_next_done",   bd_cnt - bd0, 1);

    // Reset mid-frame with a byte waiting in the holding register
    push(8'h81);
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (16) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat (SH) @(posedge clk); #1 sclk = 1'b1;
      repeat (SH) @(posedge clk); #1 sclk = 1'b0;
    end
    push(8'h81);
    check("pre_rst_hold_full", tx_if.tx_ready, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    check("mid_rst_miso",        miso,           1'b0);
    check("mid_rst_miso_oe",     miso_oe,        1'b0);
    check("mid_rst_tx_ready",    tx_if.tx_ready, 1'b1);
    check("mid_rst_byte_done",   byte_done,      1'b0);
    check("mid_rst_status_sent", status_sent,    1'b0);
    cs_n = 1'b1; sclk = 1'b0;
    repeat (4) @(posedge clk); #1 rst_n = 1'b1;
    bd0 = bd_cnt; ss0 = ss_cnt;
    host_frame(8);
    check("post_rst_byte",   rx[0],        8'hD7);
    check("post_rst_status", ss_cnt - ss0, 1);

    // tx_valid exactly in the LOAD cycle of byte 1
    fsm_state = 3'd2; bnn_result_ready = 1'b0; bnn_result_out = 4'd9;
    bd0 = bd_cnt; ss0 = ss_cnt;
    fork
      host_frame(16);
      begin
        @(negedge cs_n);
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1 tx_if.tx_byte = 8'h6E; tx_if.tx_valid = 1'b1;
        @(posedge clk); #1 tx_if.tx_valid = 1'b0;
      end
    join
    check("load_push_byte0",  rx[0],        8'h29);
    check("load_push_byte1",  rx[1],        8'h6E);
    check("load_push_status", ss_cnt - ss0, 1);
    check("load_push_done",   bd_cnt - bd0, 2);

    // Randomized frames against the byte-level model
    model_q.delete();
    for (int it = 0; it < 25; it++) begin
      fsm_state        = 3'($urandom_range(0, 7));
      bnn_result_ready = 1'($urandom_range(0, 1));
      bnn_result_out   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        push(d);
        model_q.push_back(d);
      end
      bd0 = bd_cnt; ss0 = ss_cnt;
      if ($urandom_range(0, 3) == 0) begin
        nbits = $urandom_range(1, 7);
        host_frame(nbits);
        model_q.delete();
        check("rnd_abort_no_done", bd_cnt - bd0, 0);
      end else begin
        nb = $urandom_range(1, 3);
        host_frame(8 * nb);
        exp_ss = 0;
        for (int k = 0; k < nb; k++) begin
          if (model_q.size() > 0) begin
            e = model_q.pop_front();
          end else begin
            e = status_now();
            exp_ss++;
          end
          check("rnd_byte", rx[k], e);
        end
        check("rnd_byte_done",   bd_cnt - bd0, nb);
        check("rnd_status_sent", ss_cnt - ss0, exp_ss);
      end
      check("rnd_tx_ready", tx_if.tx_ready, 1'b1);
    end

    check("status_without_done", ss_orphan, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_tx_responder.md
SPI_TX_RESPONDER -- requirements
Module: spi_tx_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the sclk/cs_n synchronizers (minimum 2).
REQ-002 SHALL have parameter CLK_SCLK_MIN_RATIO, default 8, meaning the minimum clk/sclk frequency ratio; it is documentation only and the bench asserts it.
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock, and all state is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sclk  input  1  host SPI clock, asynchronous to clk, SPI mode 0.
REQ-006 SHALL have port cs_n  input  1  host chip select, active-low, asynchronous to clk.
REQ-007 SHALL have port miso  output  1  serial data to the host, MSB first.
REQ-008 SHALL have port miso_oe  output  1  MISO output enable, high while the synchronized cs_n is low.
REQ-009 SHALL have port tx_byte  input  8  response byte from the control FSM.
REQ-010 SHALL have port tx_valid  input  1  tx_byte is valid.
REQ-011 SHALL have port tx_ready  output  1  holding register is empty; a transfer occurs when tx_valid and tx_ready are both high.
REQ-012 SHALL have port fsm_state  input  3  top FSM state, used in the status byte.
REQ-013 SHALL have port bnn_result_ready  input  1  classifier result is valid.
REQ-014 SHALL have port bnn_result_out  input  4  classifier digit.
REQ-015 SHALL have port byte_done  output  1  one-cycle pulse when the host samples the 8th bit of a byte.
REQ-016 SHALL have port status_sent  output  1  one-cycle pulse together with byte_done when the completed byte was a status byte.

Function
REQ-017 SHALL synchronize sclk and cs_n through SYNC_STAGES flops and derive sclk rise/fall pulses from the last two synchronized samples.
REQ-018 SHALL implement states IDLE, LOAD and SHIFT.
- IDLE -> LOAD when synchronized cs_n falls.
- LOAD -> SHIFT after exactly one cycle.
- SHIFT -> LOAD on the 8th sclk rise.
- Any state -> IDLE when synchronized cs_n is high.
REQ-019 In LOAD, SHALL load the shift register from the holding register if it is full, and empty the holding register.
REQ-020 In LOAD, if the holding register is empty, SHALL load the status byte {bnn_result_ready, fsm_state[2:0], bnn_result_out[3:0]}, sampled in that cycle.
REQ-021 SHALL drive miso from shift register bit 7 from the cycle after LOAD onward.
REQ-022 SHALL increment a 3-bit bit counter on each sclk rise in SHIFT, and shift the register left by one on each sclk fall when the counter is non-zero.
REQ-023 On the sclk rise that wraps the bit counter from 7 to 0, SHALL assert byte_done for one cycle (and status_sent if applicable) and enter LOAD.
REQ-024 SHALL hold tx_ready = ~hold_valid; a byte accepted in the same cycle as LOAD goes to the holding register and is not used by that LOAD.
REQ-025 SHALL keep an unconsumed holding byte unchanged across cs_n deassertion; it is sent in the next frame.
REQ-026 If cs_n rises mid-byte, SHALL discard the partial byte: no byte_done, bit counter cleared, IDLE.
REQ-027 SHALL drive miso low whenever miso_oe is low.
REQ-028 SHALL ignore sclk edges while in IDLE and during the LOAD cycle.

Reset
REQ-029 While rst_n is low, SHALL hold:
- miso = 0, miso_oe = 0, tx_ready = 1, byte_done = 0, status_sent = 0;
- state IDLE, bit counter 0, shift register 8'h00, holding register empty;
- synchronizer flops preset to sclk = 0, cs_n = 1.
REQ-030 SHALL apply reset asynchronously on rst_n falling, release synchronously, and accept the first transfer on the first clk edge after release.

Structure
REQ-031 SHALL place the state enum (IDLE/LOAD/SHIFT) and the status-byte field positions in the shared package bnn_pkg.
REQ-032 SHALL instantiate the sub-module bit_synchronizer, parameterized by depth and reset value, once each for sclk and cs_n.
REQ-033 SHALL be purely synchronous to clk apart from the synchronizer inputs, with no latches.

Verification
REQ-034 Scenario: push tx_byte 8'hC3, then cs_n low and 8 sclk cycles at clk/16 -> host samples 1100_0011, one byte_done pulse, status_sent = 0, tx_ready returns to 1.
REQ-035 Scenario: no byte pushed, fsm_state = 3'd5, bnn_result_ready = 1, bnn_result_out = 4'd7, then 1 byte clocked -> host reads 8'hD7, byte_done and status_sent pulse together.
REQ-036 Scenario: push 8'hA5, then 8'h3C once tx_ready is high, then a 16-sclk frame -> host reads A5 then 3C with no gap, exactly 2 byte_done pulses.
REQ-037 Scenario: push 8'hF0, raise cs_n after 4 sclk -> no byte_done; next 8-sclk frame returns the status byte and 8'hF0 is lost.
REQ-038 Scenario: push 8'h81 while cs_n is high, then pulse rst_n low mid-frame -> all outputs at reset values, holding register empty, next frame returns the status byte.
REQ-039 Scenario: tx_valid asserted in the LOAD cycle of byte 1 -> byte 1 is the status byte and byte 2 is the pushed value.
